// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop.
// Each bit is held for Prescale cycles of the oversampled UART clock.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [5:0]            r_edge_cnt;
  logic [5:0]            w_edge_next;
  logic [5:0]            r_prescale;
  logic [BW-1:0]         r_bit_cnt;
  logic [BW-1:0]         w_bit_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_tx_next;

  // Prescale of 0 wraps to 63 here, giving 64 cycles per bit.
  assign w_last   = (r_edge_cnt == r_prescale - 6'd1);
  assign w_accept = (r_state == IDLE) && Data_Valid;

  always_comb begin
    w_next_state = r_state;
    w_bit_next   = r_bit_cnt;
    w_edge_next  = w_last ? 6'd0 : r_edge_cnt + 6'd1;
    case (r_state)
      IDLE: begin
        w_edge_next = 6'd0;
        w_bit_next  = '0;
        if (w_accept) w_next_state = START;
      end
      START: begin
        if (w_last) w_next_state = DATA;
      end
      DATA: begin
        if (w_last) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_next   = '0;
            w_next_state = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_last) w_next_state = STOP;
      end
      STOP: begin
        if (w_last) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Line value for the upcoming cycle, so TX_OUT is a plain flop.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_next_state)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_data[w_bit_next];
      PARITY:  w_tx_next = r_par_bit;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= '0;
      r_prescale <= 6'd0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_edge_cnt <= w_edge_next;
      r_bit_cnt  <= w_bit_next;
      TX_OUT     <= w_tx_next;
      Busy       <= (w_next_state != IDLE);
      if (w_accept) begin
        r_data     <= P_DATA;
        r_par_en   <= PAR_EN;
        r_prescale <= Prescale;
        r_par_bit  <= (^P_DATA) ^ PAR_TYP;
      end
    end
  end

endmodule
